// File: rtl/pm_pkg.sv
// -----------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the streaming pattern matcher.
//   - pm_state_e      : run-control state encoding
//   - pm_len_w()      : width of a length/count field able to hold 0..n
//   - pm_chunk_offset(): bit ordering helper. Chunks are MSB-first: bit w-1
//                        of a chunk is the earliest bit in the stream, so bit
//                        j sits w-1-j positions after the chunk's first bit.
// -----------------------------------------------------------------------------
package pm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } pm_state_e;

  // Bits needed to represent the values 0..n inclusive.
  function automatic int pm_len_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Stream position of chunk bit j relative to the chunk's first bit.
  function automatic int pm_chunk_offset(input int j, input int w);
    return w - 1 - j;
  endfunction

endpackage

// File: rtl/pm_popcount.sv
// -----------------------------------------------------------------------------
// pm_popcount
// Combinational population count of a W-bit vector.
// Ports:
//   bits  in  W                 vector to count
//   count out pm_len_w(W)       number of ones in bits
// -----------------------------------------------------------------------------
module pm_popcount
  import pm_pkg::*;
#(
  parameter  int W    = 16,
  localparam int CNTW = pm_len_w(W)
) (
  input  logic [W-1:0]    bits,
  output logic [CNTW-1:0] count
);

  // NOTE: every variable written in always_comb gets a default before any
  // conditional or loop updates it; otherwise a path that skips the write
  // would infer a latch.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNTW'(bits[i]);
    end
  end

endmodule

// File: rtl/pattern_match_stream.sv
// -----------------------------------------------------------------------------
// pattern_match_stream
// Counts every occurrence, overlapping ones included, of a runtime-loaded bit
// pattern in a serial stream delivered as W-bit MSB-first chunks.
//
// Optional feature: define PM_WILDCARD_EN to add input pat_mask; a 0 bit in
// the mask makes that pattern position don't-care.
//
// Ports:
//   clk          in   1        clock
//   reset        in   1        asynchronous, active-high
//   start        in   1        pulse: latch pattern, clear count, begin a run
//   pat_data     in   P        pattern, bit pat_len-1 matched first
//   pat_len      in   LW       active pattern length, legal 1..P
//   pat_mask     in   P        (PM_WILDCARD_EN only) 1 = compare, 0 = ignore
//   in_valid     in   1        chunk valid
//   in_ready     out  1        chunk accepted when in_valid & in_ready
//   in_data      in   W        chunk, bit W-1 earliest in stream
//   in_last      in   1        final chunk of the run
//   match_count  out  CW       occurrences found in current/last run
//   count_sat    out  1        match_count clamped at all-ones (sticky)
//   busy         out  1        run in progress (RUN or FLUSH)
//   done         out  1        run complete, match_count final
//   err          out  1        pulse: start rejected for illegal pat_len
//
// Pipeline: stage 1 registers the window history and the valid-match vector
// of the accepted chunk; stage 2 adds its popcount into match_count.
// -----------------------------------------------------------------------------
module pattern_match_stream
  import pm_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int P  = 8,
  parameter  int CW = 16,
  localparam int LW = pm_len_w(P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [P-1:0]  pat_data,
  input  logic [LW-1:0] pat_len,
`ifdef PM_WILDCARD_EN
  input  logic [P-1:0]  pat_mask,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic [CW-1:0] match_count,
  output logic          count_sat,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int WINW = W + P - 1;              // window: history + new chunk
  localparam int HW   = (P > 1) ? P - 1 : 1;    // history bits carried over
  localparam int PCW  = pm_len_w(W);            // popcount width
  localparam int SUMW = ((CW > PCW) ? CW : PCW) + 1;

  pm_state_e state_q, state_d;

  logic [P-1:0]    pat_q;       // latched pattern
  logic [P-1:0]    care_q;      // positions that must match (length & mask)
  logic [LW-1:0]   len_q;       // latched pattern length
  logic [LW-1:0]   bit_cnt_q;   // stream bits seen, saturating at P
  logic [HW-1:0]   hist_q;      // last P-1 stream bits before the next chunk
  logic [W-1:0]    match_q;     // stage-1 valid-match vector
  logic [CW-1:0]   count_q;
  logic            sat_q;
  logic            err_q;

  logic [P-1:0]    mask_in;
  logic [P-1:0]    care_new;
  logic            idle_like;
  logic            len_ok;
  logic            start_ok;
  logic            start_bad;
  logic            accept;
  logic [WINW-1:0] window;
  logic [W-1:0]    match_d;
  logic [LW-1:0]   bit_cnt_d;
  logic [PCW-1:0]  pop;
  logic [SUMW-1:0] sum;
  logic [CW-1:0]   count_d;
  logic            sat_d;

`ifdef PM_WILDCARD_EN
  assign mask_in = pat_mask;
`else
  assign mask_in = '1;
`endif

  // ---------------------------------------------------------------------------
  // Run control
  // ---------------------------------------------------------------------------
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign len_ok    = (pat_len != '0) && (pat_len <= LW'(P));
  assign start_ok  = start && idle_like && len_ok;
  assign start_bad = start && idle_like && !len_ok;
  assign accept    = in_valid && (state_q == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Stage 2 absorbs the last match vector on the edge leaving FLUSH,
        // so the count is final when DONE is entered.
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err         = err_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;

  // ---------------------------------------------------------------------------
  // Stage 1: window and parallel match
  // ---------------------------------------------------------------------------
  // Positions at or above pat_len are outside the pattern and never compared.
  always_comb begin
    care_new = '0;
    for (int k = 0; k < P; k++) begin
      care_new[k] = (LW'(k) < pat_len) && mask_in[k];
    end
  end

  // Window bit 0 is the newest bit; only the history part needs storage,
  // the rest is the chunk being accepted this cycle.
  generate
    if (P > 1) begin : g_window
      assign window = {hist_q, in_data};
    end else begin : g_window_p1
      assign window = in_data;
    end
  endgenerate

  // Alignment j ends at window bit j: pattern bit k is compared with window
  // bit j+k. It is valid only once pat_len bits of the run exist up to and
  // including its end bit, which makes every cross-chunk match appear in
  // exactly one chunk's vector.
  always_comb begin
    match_d = '0;
    if (accept) begin
      for (int j = 0; j < W; j++) begin
        match_d[j] = ~|((window[j +: P] ^ pat_q) & care_q) &&
                     (int'(bit_cnt_q) + pm_chunk_offset(j, W) >= int'(len_q) - 1);
      end
    end
  end

  always_comb begin
    if (int'(bit_cnt_q) + W >= P) bit_cnt_d = LW'(P);
    else                          bit_cnt_d = bit_cnt_q + LW'(W);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: popcount and saturating accumulate
  // ---------------------------------------------------------------------------
  pm_popcount #(.W(W)) u_popcount (
    .bits  (match_q),
    .count (pop)
  );

  always_comb begin
    sum     = SUMW'(count_q) + SUMW'(pop);
    count_d = sum[CW-1:0];
    sat_d   = sat_q;
    if (sum > SUMW'({CW{1'b1}})) begin
      count_d = {CW{1'b1}};
      sat_d   = 1'b1;
    end
  end

  // NOTE: the datapath flops are reset as well, so an asynchronous reset
  // mid-run discards the pipeline and leaves no partial count behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q     <= '0;
      care_q    <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      hist_q    <= '0;
      match_q   <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        pat_q     <= pat_data;
        care_q    <= care_new;
        len_q     <= pat_len;
        bit_cnt_q <= '0;
        hist_q    <= '0;
        match_q   <= '0;
        count_q   <= '0;
        sat_q     <= 1'b0;
      end else begin
        // match_d is zero on bubbles, so stalls add nothing to the count.
        match_q <= match_d;
        count_q <= count_d;
        sat_q   <= sat_d;
        if (accept) begin
          hist_q    <= window[HW-1:0];
          bit_cnt_q <= bit_cnt_d;
        end
      end
    end
  end

endmodule
